// File: rtl/irq_sched_pkg.sv
// irq_sched_pkg: shared constants and types for the interrupt scheduler
// Holds the register addresses, the FSM state encoding and the STATUS/CTRL bit positions.
package irq_sched_pkg;
  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;
  localparam int STAT_CLAIM = 0;
  localparam int STAT_EOI   = 1;
  localparam int CTRL_GE    = 31;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;
endpackage

// File: rtl/irq_sched_if.sv
// irq_sched_if: bridge device-slot bus for the interrupt scheduler
// Signals: PrAddr (word address), Wr_en (write strobe), Data_in (write data),
// Data_out (combinational read data). master = bridge side, slave = device side.
interface irq_sched_if;
  logic [1:0]  PrAddr;
  logic        Wr_en;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  modport master (output PrAddr, output Wr_en, output Data_in, input Data_out);
  modport slave (input PrAddr, input Wr_en, input Data_in, output Data_out);
endinterface

// File: rtl/irq_sched_pick.sv
// irq_sched_pick: combinational winner selection among eligible sources
// Ports: elig (eligible vector), ptr (last-served id, IRQ_SCHED_RR_EN builds only),
// id (winning source), valid (any source eligible).
// IRQ_SCHED_RR_EN: search starts at ptr+1 and wraps; otherwise lowest index wins.
module irq_sched_pick #(
  parameter int NSRC = 6,
  parameter int IDW  = 4
) (
  input  logic [NSRC-1:0] elig,
`ifdef IRQ_SCHED_RR_EN
  input  logic [IDW-1:0]  ptr,
`endif
  output logic [IDW-1:0]  id,
  output logic            valid
);
  always_comb begin
    id = '0;
    valid = |elig;
`ifdef IRQ_SCHED_RR_EN
    // Scan from farthest to nearest so the first source after ptr ends up winning.
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (|(elig & (NSRC'(1) << ((int'(ptr) + 1 + k) % NSRC)))) id = IDW'((int'(ptr) + 1 + k) % NSRC);
    end
`else
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (|(elig & (NSRC'(1) << k))) id = IDW'(k);
    end
`endif
  end
endmodule

// File: rtl/irq_sched.sv
// irq_sched: programmable interrupt scheduler with request/claim/EOI handshake
// Ports: clk, reset (async, active high), bus (slave: PrAddr/Wr_en/Data_in/Data_out),
// dev_irq (raw level-high device lines), IRQ (registered request to the CPU).
// Registers: 0 MASK, 1 PEND (W1C), 2 CTRL {GE[31], TRIG}, 3 STATUS {state, id} / {EOI, CLAIM}.
// IRQ_SCHED_RR_EN selects round-robin priority with a last-served pointer.
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int NSRC = 6,
  parameter int IDW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  irq_sched_if.slave      bus,
  input  logic [NSRC-1:0] dev_irq,
  output logic            IRQ
);
  logic [NSRC-1:0] mask_q, mask_d, pend_q, pend_d, trig_q, trig_d, dly_q, dly_d;
  logic            ge_q, ge_d, irq_q, irq_d;
  state_t          state_q, state_d;
  logic [IDW-1:0]  id_q, id_d, win_id;
  logic            win_valid;
  logic [NSRC-1:0] elig, id_hot, serv_vec, w1c, eoi_clr, edge_v;
  logic            wr_mask, wr_pend, wr_ctrl, wr_stat, claim, eoi, still_elig;
  logic            unused;
  assign unused = ^bus.Data_in;
`ifdef IRQ_SCHED_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  irq_sched_pick #(.NSRC(NSRC), .IDW(IDW)) u_pick (.elig(elig), .ptr(ptr_q), .id(win_id), .valid(win_valid));
  assign ptr_d = eoi ? id_q : ptr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end
`else
  irq_sched_pick #(.NSRC(NSRC), .IDW(IDW)) u_pick (.elig(elig), .id(win_id), .valid(win_valid));
`endif
  assign wr_mask = bus.Wr_en && bus.PrAddr == ADDR_MASK;
  assign wr_pend = bus.Wr_en && bus.PrAddr == ADDR_PEND;
  assign wr_ctrl = bus.Wr_en && bus.PrAddr == ADDR_CTRL;
  assign wr_stat = bus.Wr_en && bus.PrAddr == ADDR_STAT;
  // Gating by state makes CLAIM win in REQ and EOI win in SERV when both bits are set.
  assign claim = wr_stat && bus.Data_in[STAT_CLAIM] && state_q == REQ;
  assign eoi = wr_stat && bus.Data_in[STAT_EOI] && state_q == SERV;
  assign elig = ge_q ? (pend_q & mask_q) : '0;
  assign id_hot = NSRC'(1) << id_q;
  assign still_elig = |(elig & id_hot);
  assign serv_vec = state_q == SERV ? id_hot : '0;
  assign w1c = wr_pend ? bus.Data_in[NSRC-1:0] : '0;
  assign eoi_clr = eoi ? (id_hot & trig_q) : '0;
  assign edge_v = dev_irq & ~dly_q;
  always_comb begin
    mask_d = wr_mask ? bus.Data_in[NSRC-1:0] : mask_q;
    trig_d = wr_ctrl ? bus.Data_in[NSRC-1:0] : trig_q;
    ge_d = wr_ctrl ? bus.Data_in[CTRL_GE] : ge_q;
    dly_d = dev_irq;
    // Edge sources: a new edge beats W1C/EOI. Level sources track the line unless in service.
    pend_d = (trig_q & (edge_v | (pend_q & ~w1c & ~eoi_clr)))
           | (~trig_q & ((serv_vec & pend_q & ~w1c) | (~serv_vec & dev_irq)));
    state_d = state_q;
    id_d = id_q;
    irq_d = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = win_valid ? REQ : IDLE;
        id_d = win_valid ? win_id : id_q;
      end
      REQ: begin
        state_d = claim ? SERV : (still_elig ? REQ : IDLE);
        irq_d = !claim && still_elig;
      end
      SERV: state_d = eoi ? IDLE : SERV;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      pend_q <= '0;
      trig_q <= '0;
      dly_q <= '0;
      ge_q <= 1'b0;
      irq_q <= 1'b0;
      state_q <= IDLE;
      id_q <= '0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      trig_q <= trig_d;
      dly_q <= dly_d;
      ge_q <= ge_d;
      irq_q <= irq_d;
      state_q <= state_d;
      id_q <= id_d;
    end
  end
  assign IRQ = irq_q;
  assign bus.Data_out = bus.PrAddr == ADDR_MASK ? 32'(mask_q)
                      : bus.PrAddr == ADDR_PEND ? 32'(pend_q)
                      : bus.PrAddr == ADDR_CTRL ? ({ge_q, 31'b0} | 32'(trig_q))
                      : ((32'(state_q) << 30) | 32'(id_q));
endmodule

// File: tb/tb_irq_sched.sv
// tb_irq_sched: directed self-checking bench for irq_sched
module tb_irq_sched;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] dev_irq;
  logic       IRQ;
  int total = 0;
  int bad = 0;
`ifdef IRQ_SCHED_RR_EN
  localparam logic [31:0] FIRST = 32'd4, SECOND = 32'd1;
`else
  localparam logic [31:0] FIRST = 32'd1, SECOND = 32'd4;
`endif
  irq_sched_if bus();
  irq_sched dut (.clk(clk), .reset(reset), .bus(bus), .dev_irq(dev_irq), .IRQ(IRQ));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.PrAddr = a;
    bus.Data_in = d;
    bus.Wr_en = 1'b1;
    @(negedge clk);
    bus.Wr_en = 1'b0;
    bus.Data_in = '0;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.PrAddr = a;
    #1;
    chk(tag, bus.Data_out, exp);
  endtask
  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'b0, IRQ}, {31'b0, exp});
  endtask
  initial begin
    reset = 1'b1;
    dev_irq = '0;
    bus.PrAddr = '0;
    bus.Wr_en = 1'b0;
    bus.Data_in = '0;
    tick(2);
    reset = 1'b0;
    chk_irq("rst_irq", 1'b0);
    rd(0, 32'h0, "rst_mask");
    rd(1, 32'h0, "rst_pend");
    rd(2, 32'h0, "rst_ctrl");
    rd(3, 32'h0, "rst_stat");
    // Level source 0 with everything masked: pending only.
    dev_irq = 6'h01;
    tick(1);
    rd(1, 32'h1, "lvl_pend_masked");
    dev_irq = 6'h00;
    tick(3);
    chk_irq("masked_no_irq", 1'b0);
    rd(1, 32'h0, "lvl_pend_drop");
    // Edge on source 2, 3-cycle latency.
    wr(0, 32'h3F);
    wr(2, 32'h8000003F);
    rd(2, 32'h8000003F, "ctrl_rb");
    dev_irq = 6'h04;
    tick(1);
    dev_irq = 6'h00;
    chk_irq("lat_t1", 1'b0);
    tick(1);
    chk_irq("lat_t2", 1'b0);
    rd(3, 32'h40000002, "req_stat2");
    tick(1);
    chk_irq("lat_t3", 1'b1);
    wr(3, 32'h1);
    chk_irq("claim_drop", 1'b0);
    rd(3, 32'h80000002, "serv_stat2");
    rd(1, 32'h04, "serv_pend2");
    wr(3, 32'h2);
    rd(1, 32'h0, "eoi_pend2");
    rd(3, 32'h00000002, "eoi_stat2");
    // Simultaneous edges on 1 and 4.
    dev_irq = 6'h12;
    tick(1);
    dev_irq = 6'h00;
    tick(2);
    chk_irq("pair_irq1", 1'b1);
    rd(3, 32'h40000000 | FIRST, "pair_first");
    wr(3, 32'h1);
    rd(3, 32'h80000000 | FIRST, "pair_serv1");
    wr(3, 32'h2);
    chk_irq("pair_gap0", 1'b0);
    tick(1);
    chk_irq("pair_gap1", 1'b0);
    tick(1);
    chk_irq("pair_irq2", 1'b1);
    rd(3, 32'h40000000 | SECOND, "pair_second");
    wr(3, 32'h3);
    wr(3, 32'h3);
    rd(1, 32'h0, "pair_pend_done");
    rd(3, SECOND, "pair_idle");
    // Level source 3 held high.
    wr(2, 32'h80000037);
    dev_irq = 6'h08;
    tick(3);
    chk_irq("lvl_irq", 1'b1);
    rd(3, 32'h40000003, "lvl_req");
    wr(3, 32'h1);
    rd(3, 32'h80000003, "lvl_serv");
    wr(3, 32'h2);
    tick(2);
    chk_irq("lvl_rereq", 1'b1);
    rd(3, 32'h40000003, "lvl_rereq_stat");
    wr(3, 32'h1);
    dev_irq = 6'h00;
    wr(3, 32'h2);
    chk_irq("lvl_drop0", 1'b0);
    tick(1);
    chk_irq("lvl_drop1", 1'b0);
    tick(1);
    chk_irq("lvl_drop2", 1'b0);
    rd(1, 32'h0, "lvl_pend_clear");
    rd(3, 32'h00000003, "lvl_idle");
    // Source 5 loses its mask while requesting.
    wr(2, 32'h8000003F);
    dev_irq = 6'h20;
    tick(1);
    dev_irq = 6'h00;
    tick(2);
    chk_irq("s5_irq", 1'b1);
    rd(3, 32'h40000005, "s5_req");
    wr(0, 32'h0);
    tick(1);
    chk_irq("s5_masked", 1'b0);
    rd(3, 32'h00000005, "s5_idle");
    wr(0, 32'h3F);
    tick(2);
    chk_irq("s5_rereq", 1'b1);
    rd(3, 32'h40000005, "s5_rereq_stat");
    wr(3, 32'h1);
    wr(0, 32'h0);
    tick(1);
    rd(3, 32'h80000005, "serv_keep_mask");
    wr(0, 32'h3F);
    dev_irq = 6'h01;
    tick(1);
    dev_irq = 6'h00;
    tick(2);
    chk_irq("no_preempt", 1'b0);
    rd(3, 32'h80000005, "no_preempt_stat");
    rd(1, 32'h21, "no_preempt_pend");
    // Reset while in service.
    reset = 1'b1;
    #1;
    chk_irq("rst_serv_irq", 1'b0);
    rd(0, 32'h0, "rst2_mask");
    rd(1, 32'h0, "rst2_pend");
    rd(2, 32'h0, "rst2_ctrl");
    rd(3, 32'h0, "rst2_stat");
    tick(1);
    reset = 1'b0;
    // Asynchronous IRQ drop.
    wr(0, 32'h3F);
    wr(2, 32'h8000003F);
    dev_irq = 6'h02;
    tick(1);
    dev_irq = 6'h00;
    tick(2);
    chk_irq("async_pre", 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_irq("async_drop", 1'b0);
    tick(1);
    reset = 1'b0;
    // W1C racing a new edge.
    wr(2, 32'h0000003F);
    dev_irq = 6'h04;
    tick(1);
    dev_irq = 6'h00;
    tick(1);
    rd(1, 32'h04, "race_pre");
    dev_irq = 6'h04;
    wr(1, 32'h04);
    rd(1, 32'h04, "race_set_wins");
    dev_irq = 6'h00;
    wr(1, 32'h04);
    rd(1, 32'h0, "w1c_clear");
    chk_irq("ge_off_irq", 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
